// File: rtl/cache_line_axi_master_if.sv
// AXI4-lite channel bundle between the cache line master and its memory slave.
interface cache_line_axi_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/cache_line_axi_master.sv
// Cache line fill/writeback master: splits a line request into sequential
// single-beat AXI4-lite transactions and returns one completion pulse.
module cache_line_axi_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int LINE_BITS     = DATA_WIDTH * WORDS_PER_LINE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [LINE_BITS-1:0]    req_wdata,
    output logic                    resp_valid,
    output logic [LINE_BITS-1:0]    resp_rdata,
    output logic                    busy,
    cache_line_axi_master_if.master axi
);
    localparam int BEAT_W      = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LINE_OFFSET = $clog2(LINE_BITS / 8);
    localparam int WORD_BYTES  = DATA_WIDTH / 8;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((1 << LINE_OFFSET) - 1);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

    state_t                state, state_next;
    logic [BEAT_W-1:0]     beat;
    logic [ADDR_WIDTH-1:0] base, beat_addr;
    logic [LINE_BITS-1:0]  line_buf, line_merged;
    logic                  aw_done, w_done, aw_fire, w_fire, last_beat, wr_phase;

    assign last_beat = (beat == LAST_BEAT);
    assign beat_addr = base + ADDR_WIDTH'(beat) * ADDR_WIDTH'(WORD_BYTES);
    assign wr_phase  = (state == WR_REQ);
    // Handshakes derived from state, not from the valids, to keep the FSM comb acyclic.
    assign aw_fire   = wr_phase & ~aw_done & axi.awready;
    assign w_fire    = wr_phase & ~w_done & axi.wready;

    always_comb begin
        line_merged = line_buf;
        line_merged[DATA_WIDTH*beat +: DATA_WIDTH] = axi.rdata;
    end

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        busy        = 1'b1;
        resp_valid  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.araddr  = beat_addr;
        axi.awaddr  = beat_addr;
        axi.wdata   = line_buf[DATA_WIDTH*beat +: DATA_WIDTH];
        axi.wstrb   = '1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_next = req_write ? WR_REQ : RD_ADDR;
            end
            RD_ADDR: begin
                axi.arvalid = 1'b1;
                if (axi.arready) state_next = RD_DATA;
            end
            RD_DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid) state_next = last_beat ? DONE : RD_ADDR;
            end
            WR_REQ: begin
                axi.awvalid = ~aw_done;
                axi.wvalid  = ~w_done;
                if ((aw_done | aw_fire) && (w_done | w_fire)) state_next = WR_RESP;
            end
            WR_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid) state_next = last_beat ? DONE : WR_REQ;
            end
            DONE: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            base       <= '0;
            line_buf   <= '0;
            resp_rdata <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (req_valid) begin
                    base     <= req_addr & ~OFFSET_MASK;
                    line_buf <= req_wdata;
                    beat     <= '0;
                end
                RD_DATA: if (axi.rvalid) begin
                    line_buf <= line_merged;
                    if (last_beat) resp_rdata <= line_merged;
                    else           beat       <= beat + 1'b1;
                end
                WR_REQ: begin
                    if (state_next == WR_RESP) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        if (aw_fire) aw_done <= 1'b1;
                        if (w_fire)  w_done  <= 1'b1;
                    end
                end
                WR_RESP: if (axi.bvalid && !last_beat) beat <= beat + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_line_axi_master.sv
// Directed bench for cache_line_axi_master with a small AXI4-lite memory slave.
module tb_cache_line_axi_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WPL = 4;
    localparam int LB = DW * WPL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LB-1:0] req_wdata = '0;
    logic          req_ready, resp_valid, busy;
    logic [LB-1:0] resp_rdata;

    int errors = 0;
    int checks = 0;

    cache_line_axi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    cache_line_axi_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy), .axi(axi)
    );

    always #5 clk = ~clk;

    // slave model state
    logic [31:0] mem [1024];
    logic [31:0] ar_log[$];
    logic [31:0] aw_log[$];
    logic [31:0] rd_addr, aw_q, w_q;
    logic        rd_pend, aw_got, w_got, b_pend, r_clear, b_clear;
    int          rd_wait, b_wait, aw_cnt;
    int          aw_stall = 0;
    int          b_count = 0, wstrb_bad = 0, wv_cycles = 0, awv_cycles = 0;

    // Reads: rvalid three cycles after AR; writes: bvalid two cycles after AW+W.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h040] = 32'h11111111;
        mem[10'h041] = 32'h22222222;
        mem[10'h042] = 32'h33333333;
        mem[10'h043] = 32'h44444444;
        axi.arready = 1'b1; axi.wready = 1'b1; axi.awready = 1'b0;
        axi.rvalid = 1'b0;  axi.bvalid = 1'b0; axi.rdata = '0;
        rd_pend = 0; aw_got = 0; w_got = 0; b_pend = 0; r_clear = 0; b_clear = 0;
        rd_wait = 0; b_wait = 0; aw_cnt = 0; rd_addr = '0; aw_q = '0; w_q = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                rd_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; r_clear = 1; b_clear = 1;
            end else begin
                if (axi.arvalid && axi.arready) begin
                    rd_pend = 1; rd_wait = 2; rd_addr = axi.araddr; ar_log.push_back(axi.araddr);
                end
                if (axi.rvalid && axi.rready) r_clear = 1;
                if (axi.awvalid && axi.awready) begin
                    aw_got = 1; aw_q = axi.awaddr; aw_log.push_back(axi.awaddr);
                end
                if (axi.wvalid && axi.wready) begin
                    w_got = 1; w_q = axi.wdata;
                    if (axi.wstrb != 4'hF) wstrb_bad++;
                end
                if (aw_got && w_got) begin
                    mem[aw_q[11:2]] = w_q; aw_got = 0; w_got = 0; b_pend = 1; b_wait = 1;
                end
                if (axi.bvalid && axi.bready) begin b_clear = 1; b_count++; end
                if (axi.wvalid)  wv_cycles++;
                if (axi.awvalid) awv_cycles++;
            end
            @(negedge clk);
            if (r_clear) begin axi.rvalid = 1'b0; r_clear = 0; end
            if (b_clear) begin axi.bvalid = 1'b0; b_clear = 0; end
            if (rd_pend) begin
                if (rd_wait > 0) rd_wait--;
                else begin axi.rvalid = 1'b1; axi.rdata = mem[rd_addr[11:2]]; rd_pend = 0; end
            end
            if (b_pend) begin
                if (b_wait > 0) b_wait--;
                else begin axi.bvalid = 1'b1; b_pend = 0; end
            end
            axi.awready = axi.awvalid && (aw_cnt == 0);
            if (!axi.awvalid)           aw_cnt = aw_stall;
            else if (aw_cnt > 0)        aw_cnt--;
        end
    end

    task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns the cycle of resp_valid counting the handshake as 0.
    task automatic do_req(input string tag, input logic wr, input logic [AW-1:0] addr,
                          input logic [LB-1:0] line, output int lat);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = line;
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!resp_valid) lat = -1;
        @(negedge clk);
        check({tag, "_pulse"}, resp_valid, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, n0, b0, wv0, awv0, viol;
        logic [LB-1:0] line_a, line_b, line_c, line_f;
        line_f = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        line_a = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        line_b = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
        line_c = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, resp_valid}, 6'b0);
        check("rst_rdata", resp_rdata, '0);
        rst = 1'b0;
        @(negedge clk);

        // fill, unaligned request address
        n0 = ar_log.size();
        do_req("fill", 1'b0, 32'h104, '0, lat);
        check("fill_lat", lat, 17);
        check("fill_line", resp_rdata, line_f);
        check("fill_ar_count", ar_log.size() - n0, 4);
        check("fill_araddr", {ar_log[n0], ar_log[n0+1], ar_log[n0+2], ar_log[n0+3]},
              {32'h100, 32'h104, 32'h108, 32'h10C});

        // writeback, then fill back the same line
        n0 = aw_log.size(); b0 = b_count;
        do_req("wb", 1'b1, 32'h200, line_a, lat);
        check("wb_lat", lat, 13);
        check("wb_awaddr", {aw_log[n0], aw_log[n0+1], aw_log[n0+2], aw_log[n0+3]},
              {32'h200, 32'h204, 32'h208, 32'h20C});
        check("wb_wstrb", wstrb_bad, 0);
        check("wb_mem", {mem[10'h083], mem[10'h082], mem[10'h081], mem[10'h080]}, line_a);
        check("wb_bcount", b_count - b0, 4);
        check("wb_rdata_kept", resp_rdata, line_f);
        do_req("refill", 1'b0, 32'h200, '0, lat);
        check("refill_line", resp_rdata, line_a);

        // awready stalled 3 cycles per beat, wready immediate
        aw_stall = 3; b0 = b_count; wv0 = wv_cycles; awv0 = awv_cycles;
        do_req("stall", 1'b1, 32'h300, line_c, lat);
        check("stall_lat", lat, 25);
        check("stall_wvalid_cycles", wv_cycles - wv0, 4);
        check("stall_awvalid_cycles", awv_cycles - awv0, 16);
        check("stall_bcount", b_count - b0, 4);
        check("stall_mem", {mem[10'h0C3], mem[10'h0C2], mem[10'h0C1], mem[10'h0C0]}, line_c);
        aw_stall = 0;

        // back-to-back writeback then fill with req_valid held
        b0 = b_count; viol = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h400; req_wdata = line_b;
        @(negedge clk);
        req_write = 1'b0; req_wdata = '0;
        n = 1;
        while (!resp_valid && n < 100) begin
            if (req_ready) viol++;
            @(negedge clk); n++;
        end
        check("b2b_wr_lat", n, 13);
        @(negedge clk);
        check("b2b_accept_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 100) begin
            if (req_ready) viol++;
            @(negedge clk); n++;
        end
        check("b2b_fill_lat", n, 17);
        check("b2b_fill_line", resp_rdata, line_b);
        check("b2b_bcount", b_count - b0, 4);
        check("busy_no_ready", viol, 0);
        @(negedge clk);

        // reset during the first RD_DATA cycle of beat 2
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!(axi.rready && axi.araddr == 32'h108) && n < 100) begin @(negedge clk); n++; end
        check("rst_mid_reached", n < 100, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", req_ready, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, resp_valid}, 6'b0);
        check("rst_mid_rdata", resp_rdata, '0);
        viol = 0;
        repeat (20) begin @(negedge clk); if (resp_valid) viol++; end
        check("rst_mid_no_resp", viol, 0);
        do_req("post_rst", 1'b0, 32'h10C, '0, lat);
        check("post_rst_lat", lat, 17);
        check("post_rst_line", resp_rdata, line_f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_line_axi_master.md
Name: cache_line_axi_master

Overview:
Cache-side AXI4-lite master that turns whole-line fill and writeback requests from the cache controller into sequential single-beat AXI4-lite transactions. It sits directly upstream of axi_ram_model. It issues one word per transaction at incrementing word addresses and returns the assembled line, or a write completion, with a single response pulse.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, AXI data width (one word per beat)
WORDS_PER_LINE, 4, words per cache line; power of two, >=1
(LINE_BITS = DATA_WIDTH*WORDS_PER_LINE, derived localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  line request valid
req_ready  out  1  high only in IDLE
req_write  in  1  1=writeback, 0=fill
req_addr  in  ADDR_WIDTH  line address; low log2(LINE_BITS/8) bits ignored (forced 0)
req_wdata  in  LINE_BITS  writeback line; word i at bits [DATA_WIDTH*i +: DATA_WIDTH]
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  LINE_BITS  filled line, same word packing; held until next fill completes
busy  out  1  state != IDLE
araddr  out  ADDR_WIDTH
arvalid  out  1
arready  in  1
rdata  in  DATA_WIDTH
rvalid  in  1
rready  out  1
awaddr  out  ADDR_WIDTH
awvalid  out  1
awready  in  1
wdata  out  DATA_WIDTH
wstrb  out  DATA_WIDTH/8  always all ones
wvalid  out  1
wready  in  1
bvalid  in  1
bready  out  1

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE. All valid/ready outputs are 0, except req_ready=1. resp_rdata=0, beat=0.
- Reset mid-transaction: abandon the transaction immediately. No resp_valid is generated. The slave may still return a stale rvalid/bvalid, which is ignored because rready/bready are 0 outside RD_DATA/WR_RESP.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: on req_valid&req_ready, latch the aligned base address, req_write and req_wdata. Clear beat. Go to WR_REQ if req_write, else RD_ADDR.
- Beat address = base + beat*(DATA_WIDTH/8). beat is a log2(WORDS_PER_LINE)-bit counter. The last beat is beat==WORDS_PER_LINE-1; the counter is never allowed to wrap.
- RD_ADDR: arvalid=1, araddr held stable. On arready, go to RD_DATA (arvalid drops next cycle).
- RD_DATA: rready=1. On rvalid, store rdata into word slot [beat]. If last beat, go to DONE; else beat++ and go to RD_ADDR.
- WR_REQ: awvalid=wvalid=1, wdata=word[beat]. AW and W are tracked independently with aw_done/w_done flags: each valid drops once its own handshake occurs. Go to WR_RESP when both are done (same cycle or different cycles). Flags are cleared on exit.
- WR_RESP: bready=1. On bvalid: if last beat, go to DONE; else beat++ and go to WR_REQ. WR_REQ always lasts >=1 cycle, so a lingering bvalid from the previous beat is never accepted.
- DONE: resp_valid=1 for exactly one cycle, then IDLE. For a fill, resp_rdata is updated with the full line before resp_valid is raised. resp_rdata is unchanged by writebacks.
- A request arriving while busy is not accepted (req_ready=0); the requester holds it.
- Minimum back-to-back: a new req can be accepted in the cycle after DONE.
- Latency against axi_ram_model (LATENCY_CYCLES=2, WORDS_PER_LINE=4), counting the req-handshake cycle as 0:
  - Fill: 4 cycles per beat; resp_valid in cycle 17.
  - Writeback: 3 cycles per beat; resp_valid in cycle 13.

Test Plan:
- Preload RAM words 0x100..0x10C with 11111111,22222222,33333333,44444444. Fill req_addr=0x104 (aligned to 0x100) -> araddr sequence 0x100,0x104,0x108,0x10C; resp_rdata=0x44444444_33333333_22222222_11111111; resp_valid in cycle 17 for one cycle.
- Writeback to 0x200 with words A0..A3 -> awaddr 0x200..0x20C, wstrb=F each beat, RAM holds A0..A3; resp_valid in cycle 13. A following fill from 0x200 returns the same line.
- Slave stub with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid holds until accepted, exactly one B per beat, line written correctly.
- Writeback followed immediately by a fill at the same address (req_valid held high) -> second req accepted the cycle after DONE; fill data equals the written data; no extra bready handshakes.
- rst asserted for 1 cycle while in RD_DATA of beat 2 -> next cycle state=IDLE, req_ready=1, all AXI valids 0, no resp_valid. A new fill then completes correctly despite the stale rvalid.
- req_valid asserted while busy -> req_ready=0 throughout; the request is accepted in the IDLE cycle after DONE.
